// File: rtl/div_alu_if.sv
// Operand/result bundle for the div_alu divider.
// The master drives operands and start; the slave returns the result and status.
interface div_alu_if #(
  parameter int unsigned XLEN = 64
);
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              signed_a;
  logic              signed_b;
  logic              start;
  logic [2*XLEN-1:0] result;
  logic              ready;
  logic              busy;

  modport master (
    output a, b, signed_a, signed_b, start,
    input  result, ready, busy
  );

  modport slave (
    input  a, b, signed_a, signed_b, start,
    output result, ready, busy
  );
endinterface

// File: rtl/div_alu.sv
// Radix-2 restoring signed/unsigned divider with divide-by-zero and overflow bypass.
// Result is {remainder, quotient}; ready pulses for one cycle in DONE.
module div_alu #(
  parameter int unsigned XLEN = 64
) (
  input logic      clk,
  input logic      rst,
  div_alu_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [2*XLEN-1:0] result_q, result_d;

  logic            a_sign, b_sign, overflow;
  logic [XLEN-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [XLEN+1:0] shifted;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    a_sign   = bus.signed_a & bus.a[XLEN-1];
    b_sign   = bus.signed_b & bus.b[XLEN-1];
    a_mag    = a_sign ? -bus.a : bus.a;
    b_mag    = b_sign ? -bus.b : bus.b;
    overflow = bus.signed_a & bus.signed_b & (bus.a == {1'b1, {(XLEN-1){1'b0}}})
               & (bus.b == {XLEN{1'b1}});

    // Shift in the next dividend bit; the extra top bit keeps the compare unsigned-safe.
    shifted  = {rem_q, quo_q[XLEN-1]};
    quo_fix  = q_neg_q ? -quo_q : quo_q;
    rem_fix  = r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          if (bus.b == '0) begin
            result_d = {bus.a, {XLEN{1'b1}}};
            state_d  = StDone;
          end else if (overflow) begin
            result_d = {{XLEN{1'b0}}, bus.a};
            state_d  = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            div_d   = b_mag;
            q_neg_d = a_sign ^ b_sign;
            r_neg_d = a_sign;
            cnt_d   = '0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (cnt_q == CntW'(XLEN)) begin
          result_d = {rem_fix, quo_fix};
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (shifted >= {2'b00, div_q}) begin
            rem_d = shifted[XLEN:0] - {1'b0, div_q};
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = (state_q == StDone);
  assign bus.busy   = (state_q == StCalc);

endmodule

// File: tb/tb_div_alu.sv
// Directed table-driven bench for div_alu (XLEN=64) plus restart and reset-abort sequences.
module tb_div_alu;

  localparam int unsigned XLEN = 64;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        sa;
    logic        sb;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_alu_if #(.XLEN(XLEN)) bus ();

  div_alu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for its ready pulse; latency counts edges after the accept edge.
  task automatic run(input vec_t v);
    int lat;
    int busy_n;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.signed_a = v.sa;
    bus.signed_b = v.sb;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 0;
    busy_n    = 0;
    while (!bus.ready && lat < 200) begin
      if (bus.busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({v.name, " ready_seen"}, {127'd0, bus.ready}, 128'd1);
    check({v.name, " latency"}, 128'(lat), 128'(v.lat));
    check({v.name, " busy_cycles"}, 128'(busy_n), 128'(v.lat));
    check({v.name, " busy_in_done"}, {127'd0, bus.busy}, 128'd0);
    check({v.name, " quotient"}, {64'd0, bus.result[63:0]}, {64'd0, v.q});
    check({v.name, " remainder"}, {64'd0, bus.result[127:64]}, {64'd0, v.r});
    @(posedge clk);
    #1;
    check({v.name, " ready_one_cycle"}, {127'd0, bus.ready}, 128'd0);
  endtask

  vec_t        vecs[12];
  logic [63:0] m1;
  logic [63:0] mn;

  initial begin
    int          nready;
    int          rlat;
    logic [127:0] rres;
    logic [127:0] prev;

    checks = 0;
    errors = 0;
    m1 = '1;
    mn = 64'h8000_0000_0000_0000;

    vecs[0]  = '{"u100_7",      64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65};
    vecs[1]  = '{"s-100_7",     64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{"div0",        64'h1234, 64'd0, 1'b0, 1'b0, m1, 64'h1234, 0};
    vecs[3]  = '{"sovf",        mn, m1, 1'b1, 1'b1, mn, 64'd0, 0};
    vecs[4]  = '{"s100_-7",     64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65};
    vecs[5]  = '{"s-100_-7",    64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b1,
                 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[6]  = '{"umax_2",      m1, 64'd2, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 65};
    vecs[7]  = '{"umin_m1",     mn, m1, 1'b0, 1'b0, 64'd0, mn, 65};
    vecs[8]  = '{"div0_prio",   mn, 64'd0, 1'b1, 1'b1, m1, mn, 0};
    vecs[9]  = '{"smin_1",      mn, 64'd1, 1'b1, 1'b1, mn, 64'd0, 65};
    vecs[10] = '{"ub_s-7",      64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65};
    vecs[11] = '{"u7_100",      64'd7, 64'd100, 1'b0, 1'b0, 64'd0, 64'd7, 65};

    rst          = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.signed_a = 1'b0;
    bus.signed_b = 1'b0;
    bus.start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", bus.result, 128'd0);
    check("reset_ready", {127'd0, bus.ready}, 128'd0);
    check("reset_busy", {127'd0, bus.busy}, 128'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run(vecs[i]);
    prev = {vecs[11].r, vecs[11].q};

    // Restart attempt and operand changes during CALC must not disturb 10/3.
    bus.a        = 64'd10;
    bus.b        = 64'd3;
    bus.signed_a = 1'b0;
    bus.signed_b = 1'b0;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    nready    = 0;
    rlat      = -1;
    rres      = '0;
    for (int lat = 0; lat < 150; lat++) begin
      if (bus.ready) begin
        nready++;
        if (rlat < 0) begin
          rlat = lat;
          rres = bus.result;
        end
      end
      if (lat == 10) check("result_held_in_calc", bus.result, prev);
      if (lat == 20) begin
        bus.a     = 64'd50;
        bus.b     = 64'd5;
        bus.start = 1'b1;
      end
      if (lat == 21) bus.start = 1'b0;
      if (lat == 40) bus.a = 64'd999;
      @(posedge clk);
      #1;
    end
    check("restart ready_count", 128'(nready), 128'd1);
    check("restart latency", 128'(rlat), 128'd65);
    check("restart quotient", {64'd0, rres[63:0]}, 128'd3);
    check("restart remainder", {64'd0, rres[127:64]}, 128'd1);

    // Abort 100/7 mid-CALC with reset; start held during reset must be ignored.
    bus.a     = 64'd100;
    bus.b     = 64'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    nready    = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.ready) nready++;
    end
    check("abort busy_before_rst", {127'd0, bus.busy}, 128'd1);
    rst = 1'b0;
    #1;
    check("abort result_in_rst", bus.result, 128'd0);
    check("abort busy_in_rst", {127'd0, bus.busy}, 128'd0);
    bus.a     = 64'd9;
    bus.b     = 64'd2;
    bus.start = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.ready) nready++;
    end
    check("abort no_accept_in_rst", {127'd0, bus.busy}, 128'd0);
    check("abort result_still_0", bus.result, 128'd0);
    bus.start = 1'b0;
    rst       = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.ready) nready++;
    end
    check("abort no_ready", 128'(nready), 128'd0);
    check("abort result_after_rst", bus.result, 128'd0);
    run('{"u9_2", 64'd9, 64'd2, 1'b0, 1'b0, 64'd4, 64'd1, 65});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_alu.md
DIV_ALU -- requirements
Module: div_alu

Interface
REQ-001 SHALL provide parameter XLEN, default 64, operand width in bits.
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-004 SHALL provide port a  input  XLEN  dividend.
REQ-005 SHALL provide port b  input  XLEN  divisor.
REQ-006 SHALL provide port signed_a  input  1  dividend is two's complement when 1.
REQ-007 SHALL provide port signed_b  input  1  divisor is two's complement when 1.
REQ-008 SHALL provide port start  input  1  request; operands are sampled in the cycle it is accepted.
REQ-009 SHALL provide port result  output  2*XLEN  {remainder[XLEN-1:0], quotient[XLEN-1:0]}.
REQ-010 SHALL provide port ready  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL provide port busy  output  1  high while a division is in progress.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in CALC is ignored, with no effect on the operation in flight.
REQ-014 SHALL latch a, b, signed_a and signed_b on acceptance; later operand changes have no effect.
REQ-015 SHALL form the operand signs as a_sign = signed_a & a[XLEN-1] and b_sign = signed_b & b[XLEN-1].
REQ-016 SHALL divide the magnitudes |a| / |b| using two's-complement absolute value.
REQ-017 SHALL make the quotient negative iff a_sign ^ b_sign, and give the remainder the sign of a_sign.
REQ-018 SHALL use a radix-2 restoring algorithm, one quotient bit per CALC cycle, for exactly XLEN CALC cycles.
REQ-019 Normal latency: start accepted at edge N; CALC at edges N+1..N+XLEN; DONE with ready=1 in the cycle after edge N+XLEN+1 (65-cycle start-to-ready for XLEN=64).
REQ-020 SHALL treat b==0 as a special case: quotient = all ones, remainder = a unmodified. The FSM goes directly to DONE, with ready in the cycle after the accepting edge.
REQ-021 SHALL treat signed overflow as a special case: signed_a & signed_b, a = 1<<(XLEN-1), b = all ones. Result: quotient = a, remainder = 0. The FSM goes directly to DONE.
REQ-022 SHALL give the b==0 case priority over the signed-overflow case.
REQ-023 SHALL assert ready only in DONE, for exactly one cycle.
REQ-024 SHALL move DONE to IDLE when start=0, and DONE to a new operation when start=1.
REQ-025 SHALL hold result stable from DONE until the next result is written; it is not cleared at start.
REQ-026 SHALL drive busy=1 in CALC only.
REQ-027 SHALL keep the internal remainder register XLEN+1 bits wide so no subtraction overflows.

Reset
REQ-028 SHALL, on rst=0 and at any time including mid-CALC, immediately force state=IDLE, result=0, ready=0, busy=0, and clear counter and working registers.
REQ-029 SHALL accept no start while rst=0; the first accept is at the first rising edge with rst=1.
REQ-030 SHALL discard any aborted division: no ready pulse, and result stays 0.

Verification
REQ-031 Unsigned 100/7, signed_a=signed_b=0 -> ready 65 cycles after start; quotient=14, remainder=2; ready high exactly 1 cycle.
REQ-032 Signed -100/7 (a=0xFFFF_FFFF_FFFF_FF9C) -> quotient=-14 (0xFFFF_FFFF_FFFF_FFF2), remainder=-2 (0xFFFF_FFFF_FFFF_FFFE).
REQ-033 Divide-by-zero, a=0x1234, b=0 -> ready the cycle after start; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234; busy never high.
REQ-034 Signed overflow, a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF, both signed -> quotient=0x8000_0000_0000_0000, remainder=0, ready the cycle after start.
REQ-035 Start 10/3, pulse start again with 50/5 at CALC cycle 20, and change a/b mid-CALC -> single ready at cycle 65; quotient=3, remainder=1.
REQ-036 Start 100/7, drive rst=0 at CALC cycle 30 for 2 cycles, then release and start 9/2 -> no ready from the aborted op; result=0 during reset; then quotient=4, remainder=1 after 65 cycles.
